// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage sitting directly in front of a synchronous-read instruction
// memory. The memory registers `pc` on every CLK_SYS edge and presents the
// addressed word on `instruction` during the following cycle. This block
// tracks that one-cycle latency (pc_q1/valid_q1) and registers the returned
// word, its address and a valid flag into the IF/ID register for decode.
//
// Features: downstream stall (the held address is replayed to the memory),
// redirect with a one-bubble flush, and halt after LAST_PC has been issued.
//
// Ports:
//   CLK_SYS      in   1         system clock, all state on rising edge
//   RST_SYS      in   1         synchronous reset, active-high
//   stall        in   1         freeze fetch and IF/ID state
//   redirect_en  in   1         load redirect_pc, flush the in-flight fetch
//   redirect_pc  in   PC_WIDTH  redirect target word address
//   instruction  in   32        memory word for the address issued last cycle
//   pc           out  PC_WIDTH  address presented to the memory (combinational)
//   instr_id     out  32        IF/ID instruction (NOP_INSTR when invalid)
//   pc_id        out  PC_WIDTH  address of instr_id
//   valid_id     out  1         instr_id is a real instruction
//   halted       out  1         fetch has stopped after LAST_PC
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                  PC_WIDTH  = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [PC_WIDTH-1:0] LAST_PC   = '1,
    parameter logic [31:0]         NOP_INSTR = 32'h08E7_0500
) (
    input  logic                CLK_SYS,
    input  logic                RST_SYS,
    input  logic                stall,
    input  logic                redirect_en,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         instr_id,
    output logic [PC_WIDTH-1:0] pc_id,
    output logic                valid_id,
    output logic                halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Fetch-side state
    state_t              state_q;
    state_t              state_d;
    logic [PC_WIDTH-1:0] pc_reg;      // next sequential address
    logic [PC_WIDTH-1:0] pc_reg_d;
    logic [PC_WIDTH-1:0] pc_q1;       // address of the word now on `instruction`
    logic [PC_WIDTH-1:0] pc_q1_d;
    logic                valid_q1;    // that word belongs to the correct path
    logic                valid_q1_d;

    // IF/ID next values
    logic [31:0]         instr_id_d;
    logic [PC_WIDTH-1:0] pc_id_d;
    logic                valid_id_d;

    // -------------------------------------------------------------------------
    // Address mux. During a stall the memory is handed back the address it
    // already holds, so the word on `instruction` is reloaded unchanged and
    // nothing is lost or duplicated when the stall releases.
    // -------------------------------------------------------------------------
    always_comb begin
        if (RST_SYS) begin
            pc = RESET_PC;
        end else if (redirect_en) begin
            pc = redirect_pc;
        end else if (stall) begin
            pc = pc_q1;
        end else begin
            pc = pc_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-value logic.
    // NOTE: every signal gets its hold value first; without these defaults the
    // branches that leave a signal untouched would infer latches.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_reg_d   = pc_reg;
        pc_q1_d    = pc_q1;
        valid_q1_d = valid_q1;
        instr_id_d = instr_id;
        pc_id_d    = pc_id;
        valid_id_d = valid_id;

        if (redirect_en) begin
            // Redirect beats stall and HALT. The word on `instruction` is from
            // the abandoned path, so IF/ID takes a bubble instead.
            pc_q1_d    = redirect_pc;
            valid_q1_d = 1'b1;
            pc_reg_d   = redirect_pc + 1'b1;
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
            // The target itself may be the final instruction: it is issued on
            // this edge, so fetch stops here just as on a sequential arrival.
            state_d    = (redirect_pc == LAST_PC) ? HALT : RUN;
        end else if (!stall) begin
            // IF/ID advances on every non-stalled edge, HALT included, which
            // lets the LAST_PC word drain out after fetch has stopped. An
            // invalid slot is replaced by the bubble word, never the raw data.
            instr_id_d = valid_q1 ? instruction : NOP_INSTR;
            pc_id_d    = pc_q1;
            valid_id_d = valid_q1;

            case (state_q)
                HALT: begin
                    // Nothing new is issued; the address registers stay frozen.
                    valid_q1_d = 1'b0;
                end
                default: begin
                    // BOOT and RUN both issue the sequential address; the
                    // first such edge after reset is what leaves BOOT.
                    pc_q1_d    = pc;
                    valid_q1_d = 1'b1;
                    pc_reg_d   = pc + 1'b1;   // wraps modulo 2**PC_WIDTH
                    state_d    = (pc == LAST_PC) ? HALT : RUN;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_SYS) begin
        if (RST_SYS) begin
            state_q  <= BOOT;
            pc_reg   <= RESET_PC;
            pc_q1    <= RESET_PC;
            valid_q1 <= 1'b0;
            instr_id <= NOP_INSTR;
            pc_id    <= '0;
            valid_id <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_reg   <= pc_reg_d;
            pc_q1    <= pc_q1_d;
            valid_q1 <= valid_q1_d;
            instr_id <= instr_id_d;
            pc_id    <= pc_id_d;
            valid_id <= valid_id_d;
        end
    end

    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Two fetch units share one stimulus: dut_a keeps the default LAST_PC (1023),
// dut_b uses LAST_PC = 8 so halting and wrap-past-1023 can be observed side
// by side. A registered-read memory model with mem[k] = 0xA5000000 | k feeds
// each unit. The reference model below describes fetch as a stream of tokens
// (an address, or -1 for "nothing useful"): one token in flight inside the
// memory, one at the IF/ID output.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h08E7_0500;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_en;
    logic [9:0]  redirect_pc;

    logic [31:0] instr_a, instr_b;
    logic [9:0]  pc_a, pc_b;
    logic [31:0] instr_id_a, instr_id_b;
    logic [9:0]  pc_id_a, pc_id_b;
    logic        valid_id_a, valid_id_b;
    logic        halted_a, halted_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .PC_WIDTH (10), .RESET_PC (10'd0), .LAST_PC (10'd1023), .NOP_INSTR (NOP)
    ) dut_a (
        .CLK_SYS (clk), .RST_SYS (rst), .stall (stall),
        .redirect_en (redirect_en), .redirect_pc (redirect_pc),
        .instruction (instr_a), .pc (pc_a), .instr_id (instr_id_a),
        .pc_id (pc_id_a), .valid_id (valid_id_a), .halted (halted_a)
    );

    instruction_fetch #(
        .PC_WIDTH (10), .RESET_PC (10'd0), .LAST_PC (10'd8), .NOP_INSTR (NOP)
    ) dut_b (
        .CLK_SYS (clk), .RST_SYS (rst), .stall (stall),
        .redirect_en (redirect_en), .redirect_pc (redirect_pc),
        .instruction (instr_b), .pc (pc_b), .instr_id (instr_id_b),
        .pc_id (pc_id_b), .valid_id (valid_id_b), .halted (halted_b)
    );

    function automatic logic [31:0] mem_word(input int a);
        return 32'hA500_0000 | 32'(a & 1023);
    endfunction

    function automatic logic [31:0] exp_word(input int tok);
        if (tok < 0) return NOP;
        return mem_word(tok);
    endfunction

    // Synchronous-read instruction memories
    always @(posedge clk) begin
        instr_a <= mem_word(int'(pc_a));
        instr_b <= mem_word(int'(pc_b));
    end

    // ---------------- reference model (index 0 = dut_a, 1 = dut_b) ----------
    int         m_last[2] = '{1023, 8};
    int         m_next[2];       // next sequential address
    int         m_replay[2];     // address the memory currently holds
    int         m_inflight[2];   // token inside the memory (-1 = none)
    int         m_out[2];        // token at IF/ID (-1 = bubble)
    bit         m_halted[2];
    logic [9:0] exp_pc[2];
    logic [9:0] obs_pc[2];

    // One clock cycle: drive inputs, sample the combinational pc, take the
    // edge, advance the model, and leave time 1 unit past the edge.
    task automatic step(input bit r, input bit s, input bit re, input int rp);
        rst         = r;
        stall       = s;
        redirect_en = re;
        redirect_pc = 10'(rp);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (r)       exp_pc[i] = 10'd0;
            else if (re) exp_pc[i] = 10'(rp);
            else if (s)  exp_pc[i] = 10'(m_replay[i]);
            else         exp_pc[i] = 10'(m_next[i]);
        end
        obs_pc[0] = pc_a;
        obs_pc[1] = pc_b;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_next[i] = 0; m_replay[i] = 0; m_inflight[i] = -1;
                m_out[i] = -1; m_halted[i] = 1'b0;
            end else if (re) begin
                m_out[i]      = -1;
                m_inflight[i] = rp;
                m_replay[i]   = rp;
                m_next[i]     = (rp + 1) % 1024;
                m_halted[i]   = (rp == m_last[i]);
            end else if (!s) begin
                m_out[i] = m_inflight[i];
                if (m_halted[i]) begin
                    m_inflight[i] = -1;
                end else begin
                    m_inflight[i] = m_next[i];
                    m_replay[i]   = m_next[i];
                    m_halted[i]   = (m_next[i] == m_last[i]);
                    m_next[i]     = (m_next[i] + 1) % 1024;
                end
            end
        end
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (obs_pc[0] !== 10'd0) begin
            failures++; $display("FAIL reset_pc: got %0d want 0", obs_pc[0]);
        end
        checks++;
        if (valid_id_a !== 1'b0 || instr_id_a !== NOP) begin
            failures++;
            $display("FAIL reset_ifid: valid=%b instr=%h want valid=0 instr=%h", valid_id_a, instr_id_a, NOP);
        end
        checks++;
        if (pc_id_a !== 10'd0) begin
            failures++; $display("FAIL reset_pc_id: got %0d want 0", pc_id_a);
        end
        checks++;
        if (halted_a !== 1'b0 || halted_b !== 1'b0 || valid_id_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_halted: halted_a=%b halted_b=%b valid_b=%b want 0 0 0", halted_a, halted_b, valid_id_b);
        end
    endtask

    task automatic test_sequential();
        step(1, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, 0);
            checks++;
            if (obs_pc[0] !== 10'(c)) begin
                failures++; $display("FAIL seq_pc cycle %0d: got %0d want %0d", c, obs_pc[0], c);
            end
            checks++;
            if (c < 1) begin
                if (valid_id_a !== 1'b0 || instr_id_a !== NOP) begin
                    failures++;
                    $display("FAIL seq_ifid cycle %0d: valid=%b instr=%h want valid=0 instr=%h", c + 1, valid_id_a, instr_id_a, NOP);
                end
            end else if (valid_id_a !== 1'b1 || pc_id_a !== 10'(c - 1) || instr_id_a !== mem_word(c - 1)) begin
                failures++;
                $display("FAIL seq_ifid cycle %0d: valid=%b pc_id=%0d instr=%h want 1 %0d %h", c + 1, valid_id_a, pc_id_a, instr_id_a, c - 1, mem_word(c - 1));
            end
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0);
        for (int c = 0; c < 5; c++) step(0, 0, 0, 0);   // issues 0..4
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0);
            checks++;
            if (obs_pc[0] !== 10'd4 || valid_id_a !== 1'b1 || pc_id_a !== 10'd3 || instr_id_a !== mem_word(3)) begin
                failures++;
                $display("FAIL stall_hold %0d: pc=%0d valid=%b pc_id=%0d instr=%h want 4 1 3 %h", k, obs_pc[0], valid_id_a, pc_id_a, instr_id_a, mem_word(3));
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            checks++;
            if (obs_pc[0] !== 10'(5 + k) || valid_id_a !== 1'b1 || pc_id_a !== 10'(4 + k) || instr_id_a !== mem_word(4 + k)) begin
                failures++;
                $display("FAIL stall_release %0d: pc=%0d valid=%b pc_id=%0d instr=%h want %0d 1 %0d %h", k, obs_pc[0], valid_id_a, pc_id_a, instr_id_a, 5 + k, 4 + k, mem_word(4 + k));
            end
        end
    endtask

    task automatic test_redirect();
        step(1, 0, 0, 0);
        for (int c = 0; c < 8; c++) step(0, 0, 0, 0);   // issues 0..7
        step(0, 0, 1, 20);
        checks++;
        if (obs_pc[0] !== 10'd20 || valid_id_a !== 1'b0 || instr_id_a !== NOP) begin
            failures++;
            $display("FAIL redirect_bubble: pc=%0d valid=%b instr=%h want 20 0 %h", obs_pc[0], valid_id_a, instr_id_a, NOP);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            checks++;
            if (obs_pc[0] !== 10'(21 + k) || valid_id_a !== 1'b1 || pc_id_a !== 10'(20 + k) || instr_id_a !== mem_word(20 + k)) begin
                failures++;
                $display("FAIL redirect_target %0d: pc=%0d valid=%b pc_id=%0d want %0d 1 %0d", k, obs_pc[0], valid_id_a, pc_id_a, 21 + k, 20 + k);
            end
        end
    endtask

    task automatic test_halt();
        int want  = 0;
        bit found = 1'b0;
        step(1, 0, 0, 0);
        for (int n = 0; n < 20 && !found; n++) begin
            step(0, 0, 0, 0);
            if (valid_id_b) begin
                checks++;
                if (pc_id_b !== 10'(want) || instr_id_b !== mem_word(want)) begin
                    failures++; $display("FAIL halt_seq: pc_id=%0d instr=%h want %0d %h", pc_id_b, instr_id_b, want, mem_word(want));
                end
                if (pc_id_b == 10'd8) begin
                    found = 1'b1;
                    checks++;
                    if (halted_b !== 1'b1) begin
                        failures++; $display("FAIL halt_flag: got %b want 1", halted_b);
                    end
                end
                want++;
            end
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL halt_reach: LAST_PC word not seen within 20 cycles (got %b want 1)", found);
        end
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0);
            checks++;
            if (obs_pc[1] !== 10'd9 || valid_id_b !== 1'b0 || instr_id_b !== NOP || halted_b !== 1'b1) begin
                failures++;
                $display("FAIL halt_idle %0d: pc=%0d valid=%b instr=%h halted=%b want 9 0 %h 1", k, obs_pc[1], valid_id_b, instr_id_b, halted_b, NOP);
            end
        end
        step(0, 0, 1, 0);
        checks++;
        if (valid_id_b !== 1'b0 || halted_b !== 1'b0) begin
            failures++; $display("FAIL halt_resume: valid=%b halted=%b want 0 0", valid_id_b, halted_b);
        end
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 0);
            checks++;
            if (valid_id_b !== 1'b1 || pc_id_b !== 10'(k)) begin
                failures++; $display("FAIL halt_resume_seq %0d: valid=%b pc_id=%0d want 1 %0d", k, valid_id_b, pc_id_b, k);
            end
        end
        // Redirect straight onto the last address: fetched once, then halted.
        step(0, 0, 1, 8);
        checks++;
        if (halted_b !== 1'b1 || valid_id_b !== 1'b0) begin
            failures++; $display("FAIL redirect_last: halted=%b valid=%b want 1 0", halted_b, valid_id_b);
        end
        step(0, 0, 0, 0);
        checks++;
        if (valid_id_b !== 1'b1 || pc_id_b !== 10'd8 || instr_id_b !== mem_word(8)) begin
            failures++; $display("FAIL redirect_last_drain: valid=%b pc_id=%0d want 1 8", valid_id_b, pc_id_b);
        end
        step(0, 0, 0, 0);
        checks++;
        if (valid_id_b !== 1'b0 || instr_id_b !== NOP) begin
            failures++; $display("FAIL redirect_last_stop: valid=%b instr=%h want 0 %h", valid_id_b, instr_id_b, NOP);
        end
    endtask

    task automatic test_wrap();
        int seq[4] = '{1022, 1023, 0, 1};
        step(1, 0, 0, 0);
        step(0, 0, 1, 1022);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            checks++;
            if (valid_id_b !== 1'b1 || pc_id_b !== 10'(seq[k]) || instr_id_b !== mem_word(seq[k]) || halted_b !== 1'b0) begin
                failures++;
                $display("FAIL wrap_seq %0d: valid=%b pc_id=%0d halted=%b want 1 %0d 0", k, valid_id_b, pc_id_b, halted_b, seq[k]);
            end
            // dut_a has LAST_PC=1023: it drains 1022, 1023 and then goes idle.
            checks++;
            if (valid_id_a !== (k < 2) || (k < 2 && pc_id_a !== 10'(seq[k])) || halted_a !== 1'b1) begin
                failures++;
                $display("FAIL wrap_last_a %0d: valid=%b pc_id=%0d halted=%b want %b %0d 1", k, valid_id_a, pc_id_a, halted_a, k < 2, seq[k]);
            end
        end
        step(0, 1, 1, 5);   // redirect and stall together: redirect wins
        checks++;
        if (obs_pc[0] !== 10'd5 || obs_pc[1] !== 10'd5 || valid_id_b !== 1'b0 || instr_id_b !== NOP || halted_a !== 1'b0) begin
            failures++;
            $display("FAIL redirect_stall: pc_a=%0d pc_b=%0d valid_b=%b halted_a=%b want 5 5 0 0", obs_pc[0], obs_pc[1], valid_id_b, halted_a);
        end
        step(0, 0, 0, 0);
        checks++;
        if (valid_id_a !== 1'b1 || pc_id_a !== 10'd5 || valid_id_b !== 1'b1 || pc_id_b !== 10'd5) begin
            failures++;
            $display("FAIL redirect_stall_target: a=(%b,%0d) b=(%b,%0d) want (1,5) (1,5)", valid_id_a, pc_id_a, valid_id_b, pc_id_b);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0);
        for (int c = 0; c < 12; c++) step(0, 0, 0, 0);  // next address is 12
        step(1, 0, 0, 0);
        checks++;
        if (obs_pc[0] !== 10'd0 || valid_id_a !== 1'b0 || instr_id_a !== NOP) begin
            failures++;
            $display("FAIL reset_mid: pc=%0d valid=%b instr=%h want 0 0 %h", obs_pc[0], valid_id_a, instr_id_a, NOP);
        end
        step(0, 0, 0, 0);
        checks++;
        if (obs_pc[0] !== 10'd0 || valid_id_a !== 1'b0) begin
            failures++; $display("FAIL reset_mid_release1: pc=%0d valid=%b want 0 0", obs_pc[0], valid_id_a);
        end
        step(0, 0, 0, 0);
        checks++;
        if (valid_id_a !== 1'b1 || pc_id_a !== 10'd0 || instr_id_a !== mem_word(0)) begin
            failures++; $display("FAIL reset_mid_release2: valid=%b pc_id=%0d instr=%h want 1 0 %h", valid_id_a, pc_id_a, instr_id_a, mem_word(0));
        end
    endtask

    task automatic test_random();
        int picks[5] = '{0, 7, 8, 1022, 1023};
        logic        v[2];
        logic [9:0]  p[2];
        logic [31:0] w[2];
        logic        h[2];
        int          fails_before = failures;
        step(1, 0, 0, 0);
        for (int n = 0; n < 800; n++) begin
            bit r  = ($urandom_range(0, 59) == 0);
            bit re = ($urandom_range(0, 9) == 0);
            bit s  = ($urandom_range(0, 3) == 0);
            int rp = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 4)] : int'($urandom_range(0, 1023));
            step(r, s, re, rp);
            v[0] = valid_id_a; p[0] = pc_id_a; w[0] = instr_id_a; h[0] = halted_a;
            v[1] = valid_id_b; p[1] = pc_id_b; w[1] = instr_id_b; h[1] = halted_b;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_pc[i] !== exp_pc[i] || v[i] !== (m_out[i] >= 0) || w[i] !== exp_word(m_out[i]) ||
                    h[i] !== m_halted[i] || (m_out[i] >= 0 && p[i] !== 10'(m_out[i]))) begin
                    failures++;
                    if (failures - fails_before <= 10)
                        $display("FAIL random dut%0d cycle %0d: pc=%0d valid=%b pc_id=%0d instr=%h halted=%b want pc=%0d token=%0d instr=%h halted=%b",
                                 i, n, obs_pc[i], v[i], p[i], w[i], h[i], exp_pc[i], m_out[i], exp_word(m_out[i]), m_halted[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
